ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameters SHALL be: AW, default 4, address width; DW, default 8, data width.
REQ-002 Clock and reset ports SHALL be:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset.
REQ-003 Per-client ports SHALL be as follows, with i = 0,1:
- req_i  in  1  request.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  AW  address.
- wdata_i  in  DW  write data.
- gnt_i  out  1  request accepted this cycle.
- rvalid_i  out  1  read data valid.
- rdata_i  out  DW  read data.
REQ-004 RAM-side ports SHALL be as follows:
- ram_wr_en_a  out  1
- ram_addr_a  out  AW
- ram_data_in_a  out  DW
- ram_rd_en_b  out  1
- ram_addr_b  out  AW
- ram_data_out_b  in  DW  valid one cycle after ram_rd_en_b is sampled.

Function
REQ-005 Port A (write) and port B (read) SHALL be arbitrated independently; one write and one read SHALL be grantable in the same cycle.
REQ-006 Each port SHALL have a round-robin arbiter with a 1-bit last-grant pointer; on contention the client not granted last on that port wins.
REQ-007 A lone requester on a port SHALL be granted immediately, and the port's pointer SHALL update to it.
REQ-008 gnt_i SHALL be combinational, asserted in the cycle req_i=1 and client i wins its port; at most one gnt per port per cycle.
REQ-009 Clients SHALL hold req, we, addr and wdata stable until gnt; a client with gnt=1 and req still high next cycle is a new request.
REQ-010 On a write grant, ram_wr_en_a, ram_addr_a and ram_data_in_a SHALL be registered at the grant edge, so they drive the RAM for exactly one cycle after gnt.
REQ-011 When no write is granted, ram_wr_en_a SHALL be 0 next cycle; ram_addr_a and ram_data_in_a SHALL hold their last values.
REQ-012 On a read grant, ram_rd_en_b and ram_addr_b SHALL be registered at the grant edge.
REQ-013 A 2-stage {valid, client-id} tag pipeline SHALL route ram_data_out_b to the owning client.
REQ-014 rvalid_i SHALL pulse for one cycle exactly 2 cycles after gnt_i for a read, with rdata_i registered alongside.
REQ-015 rdata_i SHALL hold its value when rvalid_i=0.
REQ-016 Same-cycle hazard: if a read and a write to the same address are granted in the same cycle, the read SHALL return the new write data. This forwarding SHALL be captured in the tag pipeline, independent of RAM read-during-write behaviour.
REQ-017 A read granted one cycle after a write to the same address SHALL return RAM contents; no forwarding is needed.
REQ-018 Back-to-back reads SHALL sustain one grant per cycle, with rvalid in the same order as the grants.

Reset
REQ-019 While rst=0 at a clock edge, the following SHALL clear to 0:
- ram_wr_en_a, ram_rd_en_b, ram_addr_a, ram_addr_b, ram_data_in_a
- all tag valids
- rvalid_0 and rvalid_1
- rdata_0 and rdata_1
- both round-robin pointers, so client 0 has priority first.
REQ-020 gnt_0 and gnt_1 SHALL be 0 while rst=0, regardless of req.
REQ-021 Reset asserted mid-read SHALL discard the in-flight read; no rvalid SHALL appear after reset releases.

Structure
REQ-022 A shared package SHALL hold the default AW and DW, and the client-id type (1 bit).
REQ-023 One sub-module, rr_arb2 (2-way round-robin with pointer, reset, gnt vector), SHALL be instantiated once per port.
REQ-024 The block SHALL contain no storage array and SHALL instantiate no RAM; target size is 150-250 lines.

Verification
REQ-025 After reset, client 0 writes addr 3 = 0x2A: gnt_0 in cycle 0; next cycle ram_wr_en_a=1, ram_addr_a=3, ram_data_in_a=0x2A.
REQ-026 Both clients request writes every cycle for 4 cycles: grants alternate 0,1,0,1, starting with client 0.
REQ-027 Client 0 reads addr 3 while client 1 writes addr 5 in the same cycle: both granted; rvalid_0 two cycles later with rdata_0=0x2A.
REQ-028 Same-cycle write addr 7 = 0x55 (client 1) and read addr 7 (client 0): rdata_0=0x55 at rvalid_0.
REQ-029 Client 1 issues reads to addrs 0-15 back-to-back after addr i was preloaded with i*3: 16 consecutive rvalid_1 pulses with data 0,3,...,45 in order.
REQ-030 rst=0 asserted one cycle after a read grant: no rvalid after release, and all outputs are 0 during reset.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the two-client RAM port arbiter: default widths,
// client identifier and the read-return tag carried down the pipeline.
package ram_port_arbiter_pkg;

  localparam int DEF_AW = 4;
  localparam int DEF_DW = 8;

  typedef logic client_id_t;

  // One stage of the read-return tag: who owns the read and whether the
  // data comes from a same-cycle write instead of the RAM.
  typedef struct packed {
    logic       valid;
    client_id_t id;
    logic       fwd;
  } tag_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Client-side bus of the arbiter: two request/grant clients with read return.
// req_i acts as valid and gnt_i as ready; a request transfers in the cycle both
// are high, and the client holds we/addr/wdata stable until that cycle.
interface ram_port_arbiter_if
  import ram_port_arbiter_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);

  logic          req_0;
  logic          we_0;
  logic [AW-1:0] addr_0;
  logic [DW-1:0] wdata_0;
  logic          gnt_0;
  logic          rvalid_0;
  logic [DW-1:0] rdata_0;

  logic          req_1;
  logic          we_1;
  logic [AW-1:0] addr_1;
  logic [DW-1:0] wdata_1;
  logic          gnt_1;
  logic          rvalid_1;
  logic [DW-1:0] rdata_1;

  modport master (
    output req_0, we_0, addr_0, wdata_0,
    output req_1, we_1, addr_1, wdata_1,
    input  gnt_0, rvalid_0, rdata_0,
    input  gnt_1, rvalid_1, rdata_1
  );

  modport slave (
    input  req_0, we_0, addr_0, wdata_0,
    input  req_1, we_1, addr_1, wdata_1,
    output gnt_0, rvalid_0, rdata_0,
    output gnt_1, rvalid_1, rdata_1
  );

endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a one-bit pointer; grants are combinational
// and forced low while reset is asserted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // Pointer names the client that wins a tie; it flips away from whoever
  // was granted last, so reset value 0 gives client 0 first priority.
  logic prio_q;

  always_comb begin
    gnt = 2'b00;
    if (rst) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prio_q <= 1'b0;
    end else if (gnt[0]) begin
      prio_q <= 1'b1;
    end else if (gnt[1]) begin
      prio_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates two clients onto a dual-port RAM: port A carries writes, port B
// carries reads, each with its own round-robin arbiter and a tagged read return.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  ram_port_arbiter_if.slave cl,
  output logic          ram_wr_en_a,
  output logic [AW-1:0] ram_addr_a,
  output logic [DW-1:0] ram_data_in_a,
  output logic          ram_rd_en_b,
  output logic [AW-1:0] ram_addr_b,
  input  logic [DW-1:0] ram_data_out_b
);

  logic [1:0]    wr_req, rd_req, wr_gnt, rd_gnt;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic          fwd_hit;

  assign wr_req = {cl.req_1 &  cl.we_1, cl.req_0 &  cl.we_0};
  assign rd_req = {cl.req_1 & ~cl.we_1, cl.req_0 & ~cl.we_0};

  rr_arb2 u_wr_arb (.clk(clk), .rst(rst), .req(wr_req), .gnt(wr_gnt));
  rr_arb2 u_rd_arb (.clk(clk), .rst(rst), .req(rd_req), .gnt(rd_gnt));

  assign cl.gnt_0 = wr_gnt[0] | rd_gnt[0];
  assign cl.gnt_1 = wr_gnt[1] | rd_gnt[1];

  always_comb begin
    wr_addr = wr_gnt[1] ? cl.addr_1  : cl.addr_0;
    wr_data = wr_gnt[1] ? cl.wdata_1 : cl.wdata_0;
    rd_addr = rd_gnt[1] ? cl.addr_1  : cl.addr_0;
    fwd_hit = (|wr_gnt) && (|rd_gnt) && (wr_addr == rd_addr);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ram_wr_en_a   <= 1'b0;
      ram_addr_a    <= '0;
      ram_data_in_a <= '0;
    end else begin
      ram_wr_en_a <= |wr_gnt;
      if (|wr_gnt) begin
        ram_addr_a    <= wr_addr;
        ram_data_in_a <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ram_rd_en_b <= 1'b0;
      ram_addr_b  <= '0;
    end else begin
      ram_rd_en_b <= |rd_gnt;
      if (|rd_gnt) begin
        ram_addr_b <= rd_addr;
      end
    end
  end

  // Stage 1 lines up with ram_rd_en_b, stage 2 with ram_data_out_b.
  tag_t          tag1_q, tag2_q;
  logic [DW-1:0] fwd1_q, fwd2_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tag1_q <= '0;
      tag2_q <= '0;
      fwd1_q <= '0;
      fwd2_q <= '0;
    end else begin
      tag1_q.valid <= |rd_gnt;
      tag1_q.id    <= rd_gnt[1];
      tag1_q.fwd   <= fwd_hit;
      fwd1_q       <= wr_data;
      tag2_q       <= tag1_q;
      fwd2_q       <= fwd1_q;
    end
  end

  logic          rvalid0, rvalid1;
  logic [DW-1:0] rsel, rdata0_q, rdata1_q;

  assign rvalid0 = tag2_q.valid & (tag2_q.id == 1'b0);
  assign rvalid1 = tag2_q.valid & (tag2_q.id == 1'b1);
  assign rsel    = tag2_q.fwd ? fwd2_q : ram_data_out_b;

  // Read data is steered straight from the RAM in its valid cycle and held
  // in a register for every cycle after that.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (rvalid0) rdata0_q <= rsel;
      if (rvalid1) rdata1_q <= rsel;
    end
  end

  assign cl.rvalid_0 = rvalid0;
  assign cl.rvalid_1 = rvalid1;
  assign cl.rdata_0  = rvalid0 ? rsel : rdata0_q;
  assign cl.rdata_1  = rvalid1 ? rsel : rdata1_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus random
// traffic scored against a behavioural memory/arbitration model.
module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;

  localparam int AW = DEF_AW;
  localparam int DW = DEF_DW;
  localparam int QW = 32 + 1 + DW;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  ram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  logic          ram_wr_en_a, ram_rd_en_b;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [DW-1:0] ram_data_in_a, ram_data_out_b;

  ram_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .cl(bus),
    .ram_wr_en_a(ram_wr_en_a), .ram_addr_a(ram_addr_a), .ram_data_in_a(ram_data_in_a),
    .ram_rd_en_b(ram_rd_en_b), .ram_addr_b(ram_addr_b), .ram_data_out_b(ram_data_out_b)
  );

  // Synchronous RAM: read data one cycle after rd_en, old data on collision.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_rd_en_b) ram_data_out_b <= mem[ram_addr_b];
    if (ram_wr_en_a) mem[ram_addr_a] <= ram_data_in_a;
  end

  // ---------------- scoreboard / reference model ----------------
  logic [QW-1:0] exp_q[$];
  logic [DW-1:0] ref_mem [DEPTH];
  bit            mon_en = 1'b0;
  int            w_last = -1, r_last = -1, ew, er;
  logic          e_wr_en = 1'b0, e_rd_en = 1'b0, exp_g0, exp_g1, exp_v0, exp_v1;
  logic [AW-1:0] e_addr_a = '0, e_addr_b = '0, waddr, raddr;
  logic [DW-1:0] e_din_a = '0, hold0 = '0, hold1 = '0, exp_d0, exp_d1, wdat, rd_exp;
  logic [QW-1:0] head;

  function automatic int pick(input logic r0, input logic r1, input int last);
    if (r0 && r1) return (last == 0) ? 1 : 0;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      ew = -1;
      er = -1;
      if (rst) begin
        ew = pick(bus.req_0 & bus.we_0, bus.req_1 & bus.we_1, w_last);
        er = pick(bus.req_0 & ~bus.we_0, bus.req_1 & ~bus.we_1, r_last);
      end
      exp_g0 = (ew == 0) || (er == 0);
      exp_g1 = (ew == 1) || (er == 1);
      checks++;
      if (bus.gnt_0 !== exp_g0 || bus.gnt_1 !== exp_g1) begin
        errors++;
        $display("FAIL sb_gnt cyc %0d got %b%b want %b%b", cyc, bus.gnt_1, bus.gnt_0, exp_g1, exp_g0);
      end
      checks++;
      if (ram_wr_en_a !== e_wr_en || ram_addr_a !== e_addr_a || ram_data_in_a !== e_din_a) begin
        errors++;
        $display("FAIL sb_port_a cyc %0d got en=%b a=%h d=%h want en=%b a=%h d=%h", cyc,
                 ram_wr_en_a, ram_addr_a, ram_data_in_a, e_wr_en, e_addr_a, e_din_a);
      end
      checks++;
      if (ram_rd_en_b !== e_rd_en || ram_addr_b !== e_addr_b) begin
        errors++;
        $display("FAIL sb_port_b cyc %0d got en=%b a=%h want en=%b a=%h", cyc,
                 ram_rd_en_b, ram_addr_b, e_rd_en, e_addr_b);
      end
      exp_v0 = 1'b0; exp_v1 = 1'b0; exp_d0 = hold0; exp_d1 = hold1;
      if (exp_q.size() > 0 && exp_q[0][QW-1 -: 32] == 32'(cyc)) begin
        head = exp_q.pop_front();
        if (head[DW]) begin exp_v1 = 1'b1; exp_d1 = head[DW-1:0]; hold1 = head[DW-1:0]; end
        else          begin exp_v0 = 1'b1; exp_d0 = head[DW-1:0]; hold0 = head[DW-1:0]; end
      end
      checks++;
      if (bus.rvalid_0 !== exp_v0 || bus.rdata_0 !== exp_d0) begin
        errors++;
        $display("FAIL sb_read0 cyc %0d got v=%b d=%h want v=%b d=%h", cyc, bus.rvalid_0, bus.rdata_0, exp_v0, exp_d0);
      end
      checks++;
      if (bus.rvalid_1 !== exp_v1 || bus.rdata_1 !== exp_d1) begin
        errors++;
        $display("FAIL sb_read1 cyc %0d got v=%b d=%h want v=%b d=%h", cyc, bus.rvalid_1, bus.rdata_1, exp_v1, exp_d1);
      end
      if (!rst) begin
        exp_q.delete();
        w_last = -1; r_last = -1;
        e_wr_en = 1'b0; e_addr_a = '0; e_din_a = '0;
        e_rd_en = 1'b0; e_addr_b = '0;
        hold0 = '0; hold1 = '0;
      end else begin
        waddr = (ew == 1) ? bus.addr_1 : bus.addr_0;
        wdat  = (ew == 1) ? bus.wdata_1 : bus.wdata_0;
        raddr = (er == 1) ? bus.addr_1 : bus.addr_0;
        e_wr_en = (ew >= 0);
        e_rd_en = (er >= 0);
        if (ew >= 0) begin w_last = ew; e_addr_a = waddr; e_din_a = wdat; end
        if (er >= 0) begin
          r_last = er;
          e_addr_b = raddr;
          rd_exp = (ew >= 0 && waddr == raddr) ? wdat : ref_mem[raddr];
          exp_q.push_back({32'(cyc + 2), 1'(er), rd_exp});
        end
        if (ew >= 0) ref_mem[waddr] = wdat;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_all();
    bus.req_0 = 1'b0; bus.we_0 = 1'b0; bus.addr_0 = '0; bus.wdata_0 = '0;
    bus.req_1 = 1'b0; bus.we_1 = 1'b0; bus.addr_1 = '0; bus.wdata_1 = '0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) tick();
    rst = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    bus.req_0 = 1'b1; bus.we_0 = 1'b1; bus.req_1 = 1'b1; bus.we_1 = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.gnt_0 !== 1'b0 || bus.gnt_1 !== 1'b0 || ram_wr_en_a !== 1'b0 || ram_rd_en_b !== 1'b0 ||
        bus.rvalid_0 !== 1'b0 || bus.rvalid_1 !== 1'b0 || bus.rdata_0 !== '0 || bus.rdata_1 !== '0) begin
      errors++;
      $display("FAIL reset_state got gnt=%b%b wr=%b rd=%b rv=%b%b want all zero",
               bus.gnt_1, bus.gnt_0, ram_wr_en_a, ram_rd_en_b, bus.rvalid_1, bus.rvalid_0);
    end
    tick();
    idle_all();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    bus.req_0 = 1'b1; bus.we_0 = 1'b1; bus.addr_0 = 4'd3; bus.wdata_0 = 8'h2A;
    @(negedge clk);
    checks++;
    if (bus.gnt_0 !== 1'b1) begin errors++; $display("FAIL single_write_gnt got %b want 1", bus.gnt_0); end
    tick();
    bus.req_0 = 1'b0;
    checks++;
    if (ram_wr_en_a !== 1'b1 || ram_addr_a !== 4'd3 || ram_data_in_a !== 8'h2A) begin
      errors++;
      $display("FAIL single_write_port got en=%b a=%h d=%h want en=1 a=3 d=2a", ram_wr_en_a, ram_addr_a, ram_data_in_a);
    end
    tick();
  endtask

  task automatic test_write_contention();
    int who;
    do_reset(2);
    bus.req_0 = 1'b1; bus.we_0 = 1'b1; bus.addr_0 = 4'd8; bus.wdata_0 = 8'h81;
    bus.req_1 = 1'b1; bus.we_1 = 1'b1; bus.addr_1 = 4'd9; bus.wdata_1 = 8'h91;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      who = (bus.gnt_0 && !bus.gnt_1) ? 0 : ((bus.gnt_1 && !bus.gnt_0) ? 1 : -1);
      checks++;
      if (who !== k % 2) begin errors++; $display("FAIL contention_order step %0d got %0d want %0d", k, who, k % 2); end
      tick();
    end
    idle_all();
    tick();
  endtask

  task automatic read_return(input logic [AW-1:0] ra, input logic [AW-1:0] wa,
                             input logic [DW-1:0] wd, input logic [DW-1:0] want, input string name);
    bus.req_0 = 1'b1; bus.we_0 = 1'b0; bus.addr_0 = ra;
    bus.req_1 = 1'b1; bus.we_1 = 1'b1; bus.addr_1 = wa; bus.wdata_1 = wd;
    @(negedge clk);
    checks++;
    if (bus.gnt_0 !== 1'b1 || bus.gnt_1 !== 1'b1) begin
      errors++; $display("FAIL %s_gnt got %b%b want 11", name, bus.gnt_1, bus.gnt_0);
    end
    tick();
    idle_all();
    @(negedge clk);
    checks++;
    if (bus.rvalid_0 !== 1'b0) begin errors++; $display("FAIL %s_early got rvalid_0=%b want 0", name, bus.rvalid_0); end
    @(negedge clk);
    checks++;
    if (bus.rvalid_0 !== 1'b1 || bus.rdata_0 !== want) begin
      errors++; $display("FAIL %s_data got v=%b d=%h want v=1 d=%h", name, bus.rvalid_0, bus.rdata_0, want);
    end
    @(negedge clk);
    checks++;
    if (bus.rvalid_0 !== 1'b0 || bus.rdata_0 !== want) begin
      errors++; $display("FAIL %s_hold got v=%b d=%h want v=0 d=%h", name, bus.rvalid_0, bus.rdata_0, want);
    end
    tick();
  endtask

  task automatic test_read_after_write();
    bus.req_0 = 1'b1; bus.we_0 = 1'b1; bus.addr_0 = 4'd6; bus.wdata_0 = 8'h3C;
    tick();
    idle_all();
    bus.req_1 = 1'b1; bus.we_1 = 1'b0; bus.addr_1 = 4'd6;
    tick();
    idle_all();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.rvalid_1 !== 1'b1 || bus.rdata_1 !== 8'h3C) begin
      errors++; $display("FAIL raw_next_cycle got v=%b d=%h want v=1 d=3c", bus.rvalid_1, bus.rdata_1);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n_gnt = 0, n_val = 0, first_v = -1, last_v = -1, wait_c;
    for (int i = 0; i < DEPTH; i++) begin
      bus.req_0 = 1'b1; bus.we_0 = 1'b1; bus.addr_0 = AW'(i); bus.wdata_0 = DW'(i * 3);
      wait_c = 0;
      @(negedge clk);
      while (!bus.gnt_0 && wait_c < 4) begin tick(); @(negedge clk); wait_c++; end
      if (!bus.gnt_0) begin errors++; $display("FAIL preload_timeout addr %0d got no gnt want gnt", i); end
      tick();
    end
    idle_all();
    tick();
    bus.req_1 = 1'b1; bus.we_1 = 1'b0; bus.addr_1 = '0;
    for (int c = 0; c < DEPTH + 8; c++) begin
      @(negedge clk);
      if (bus.rvalid_1) begin
        checks++;
        if (bus.rdata_1 !== DW'(n_val * 3)) begin
          errors++; $display("FAIL b2b_data idx %0d got %h want %h", n_val, bus.rdata_1, DW'(n_val * 3));
        end
        if (first_v < 0) first_v = c;
        last_v = c;
        n_val++;
      end
      if (bus.gnt_1) n_gnt++;
      tick();
      if (n_gnt < DEPTH) bus.addr_1 = AW'(n_gnt);
      else bus.req_1 = 1'b0;
    end
    checks++;
    if (n_gnt != DEPTH || n_val != DEPTH || first_v != 2 || last_v != first_v + DEPTH - 1) begin
      errors++;
      $display("FAIL b2b_stream got gnts=%0d vals=%0d span=%0d..%0d want %0d %0d 2..%0d",
               n_gnt, n_val, first_v, last_v, DEPTH, DEPTH, DEPTH + 1);
    end
    idle_all();
  endtask

  task automatic test_random(input int n);
    bit p0 = 1'b0, p1 = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (!p0) begin
        if ($urandom_range(0, 9) < 6) begin
          bus.req_0 = 1'b1; bus.we_0 = 1'($urandom_range(0, 1));
          bus.addr_0 = AW'($urandom_range(0, 7)); bus.wdata_0 = DW'($urandom); p0 = 1'b1;
        end else bus.req_0 = 1'b0;
      end
      if (!p1) begin
        if ($urandom_range(0, 9) < 6) begin
          bus.req_1 = 1'b1; bus.we_1 = 1'($urandom_range(0, 1));
          bus.addr_1 = AW'($urandom_range(0, 7)); bus.wdata_1 = DW'($urandom); p1 = 1'b1;
        end else bus.req_1 = 1'b0;
      end
      @(negedge clk);
      if (bus.gnt_0) p0 = 1'b0;
      if (bus.gnt_1) p1 = 1'b0;
      tick();
    end
    idle_all();
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_read();
    bus.req_0 = 1'b1; bus.we_0 = 1'b0; bus.addr_0 = 4'd3;
    @(negedge clk);
    checks++;
    if (bus.gnt_0 !== 1'b1) begin errors++; $display("FAIL midreset_gnt got %b want 1", bus.gnt_0); end
    tick();
    idle_all();
    rst = 1'b0;
    bus.req_1 = 1'b1; bus.we_1 = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (bus.gnt_0 !== 1'b0 || bus.gnt_1 !== 1'b0 || ram_wr_en_a !== 1'b0 || ram_rd_en_b !== 1'b0 ||
        ram_addr_a !== '0 || ram_addr_b !== '0 || ram_data_in_a !== '0 || bus.rvalid_0 !== 1'b0 ||
        bus.rvalid_1 !== 1'b0 || bus.rdata_0 !== '0 || bus.rdata_1 !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got gnt=%b%b wr=%b rd=%b aa=%h ab=%h d=%h rv=%b%b rd0=%h rd1=%h want all zero",
               bus.gnt_1, bus.gnt_0, ram_wr_en_a, ram_rd_en_b, ram_addr_a, ram_addr_b, ram_data_in_a,
               bus.rvalid_1, bus.rvalid_0, bus.rdata_0, bus.rdata_1);
    end
    tick();
    idle_all();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (bus.rvalid_0 !== 1'b0 || bus.rvalid_1 !== 1'b0) begin
        errors++; $display("FAIL midreset_stale cyc %0d got rvalid=%b%b want 00", c, bus.rvalid_1, bus.rvalid_0);
      end
      tick();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    ram_data_out_b = '0;
    idle_all();
    rst = 1'b0;
    repeat (2) tick();
    mon_en = 1'b1;
    test_reset();
    test_single_write();
    test_write_contention();
    read_return(4'd3, 4'd5, 8'h77, 8'h2A, "rd_wr_parallel");
    read_return(4'd7, 4'd7, 8'h55, 8'h55, "same_addr_fwd");
    test_read_after_write();
    test_back_to_back();
    test_random(400);
    test_reset_mid_read();
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
